// File: rtl/dec_buffered_2x4.sv
// Buffered 2-to-4 decoder. Accepts 2-bit codes through a valid/ready
// handshake and queues them in a small FIFO. Each queued code is then replayed
// as a one-hot word that is held for HOLD cycles, with no gap between
// back-to-back codes.
module dec_buffered_2x4 #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_code,
  output logic [3:0]             out_onehot,
  output logic                   out_valid,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL        = CW'(DEPTH);
  localparam logic [7:0]    HOLD_RELOAD = 8'(HOLD - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [7:0]    hold_cnt;
  logic          push;
  logic          pop;

  function automatic logic [3:0] decode(input logic [1:0] code);
    case (code)
      2'b00:   decode = 4'b0001;
      2'b01:   decode = 4'b0010;
      2'b10:   decode = 4'b0100;
      default: decode = 4'b1000;
    endcase
  endfunction

  // Ready comes from the registered count only, so a full FIFO refuses a
  // beat even on the edge where the head is popped.
  assign in_ready = rst_n && (fifo_count < FULL);
  assign push     = in_valid && in_ready;
  // The head is consumed when idle, or when the current word's hold expires.
  assign pop      = (fifo_count != '0) && ((state == S_IDLE) || (hold_cnt == 8'd0));

  // FIFO storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_code;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Output FSM: load a decoded word, hold it, chain straight into the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      out_onehot <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            out_onehot <= decode(mem[rd_ptr]);
            out_valid  <= 1'b1;
            hold_cnt   <= HOLD_RELOAD;
            state      <= S_HOLD;
          end else begin
            out_onehot <= '0;
            out_valid  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (hold_cnt != 8'd0) begin
            hold_cnt <= hold_cnt - 8'd1;
          end else if (pop) begin
            out_onehot <= decode(mem[rd_ptr]);
            out_valid  <= 1'b1;
            hold_cnt   <= HOLD_RELOAD;
          end else begin
            out_onehot <= '0;
            out_valid  <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_buffered_2x4.sv
// Bench for dec_buffered_2x4: one HOLD=3 and one HOLD=1 instance, both checked
// every cycle against a queue-and-timer model, plus directed scenarios with
// literal expectations.
module tb_dec_buffered_2x4;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, v0, ov0, rdy0;
  logic [1:0] c0;
  logic [3:0] oh0;
  logic [2:0] cnt0;
  logic       rst1, v1, ov1, rdy1;
  logic [1:0] c1;
  logic [3:0] oh1;
  logic [2:0] cnt1;

  dec_buffered_2x4 #(.DEPTH(DEPTH), .HOLD(3)) dut0 (
    .clk(clk), .rst_n(rst0), .in_valid(v0), .in_ready(rdy0), .in_code(c0),
    .out_onehot(oh0), .out_valid(ov0), .fifo_count(cnt0)
  );

  dec_buffered_2x4 #(.DEPTH(DEPTH), .HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst1), .in_valid(v1), .in_ready(rdy1), .in_code(c1),
    .out_onehot(oh1), .out_valid(ov1), .fifo_count(cnt1)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model: queued codes (circular array), shown code, cycles left after this one
  logic [1:0] mfifo [2][DEPTH];
  int         mhead [2];
  int         msize [2];
  int         m_rem [2];
  logic       m_on  [2];
  logic [1:0] m_cur [2];

  // observations of instance 0 / 1
  logic [3:0] seen0[$];
  logic [3:0] seen1[$];
  int  peak0, rise0, acc0, ones0, fullblk0, rise1;
  logic prev_ov0, prev_ov1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i);
    logic [3:0] a_oh, e_oh;
    logic       a_ov, a_rdy, rs;
    logic [2:0] a_cnt;
    if (i == 0) begin
      a_oh = oh0; a_ov = ov0; a_rdy = rdy0; a_cnt = cnt0; rs = rst0;
    end else begin
      a_oh = oh1; a_ov = ov1; a_rdy = rdy1; a_cnt = cnt1; rs = rst1;
    end
    e_oh = m_on[i] ? 4'(1 << m_cur[i]) : 4'b0000;
    chk($sformatf("u%0d_onehot", i), a_oh, e_oh);
    chk($sformatf("u%0d_valid", i), a_ov, m_on[i]);
    chk($sformatf("u%0d_count", i), a_cnt, msize[i]);
    chk($sformatf("u%0d_ready", i), a_rdy, (rs && msize[i] < DEPTH) ? 1 : 0);
    chk($sformatf("u%0d_shape", i), a_ov ? $onehot(a_oh) : (a_oh == 4'b0000), 1);
  endtask

  // advance model i across the coming clock edge using the inputs now applied
  task automatic step(input int i);
    logic rs, vv;
    logic [1:0] cc;
    int hold;
    bit acc;
    if (i == 0) begin rs = rst0; vv = v0; cc = c0; hold = 3; end
    else        begin rs = rst1; vv = v1; cc = c1; hold = 1; end
    if (!rs) begin
      mhead[i] = 0; msize[i] = 0; m_on[i] = 1'b0; m_rem[i] = 0;
    end else begin
      acc = vv && (msize[i] < DEPTH);
      if (m_on[i] && m_rem[i] > 0) begin
        m_rem[i]--;
      end else if (msize[i] > 0) begin
        m_cur[i] = mfifo[i][mhead[i]];
        mhead[i] = (mhead[i] + 1) % DEPTH;
        msize[i]--;
        m_on[i]  = 1'b1;
        m_rem[i] = hold - 1;
      end else begin
        m_on[i] = 1'b0;
      end
      if (acc) begin
        mfifo[i][(mhead[i] + msize[i]) % DEPTH] = cc;
        msize[i]++;
      end
    end
  endtask

  // one clock cycle: compare and observe at negedge, step model, return #1 after posedge
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      cmp(0);
      cmp(1);
    end
    if (ov0) seen0.push_back(oh0);
    if (int'(cnt0) > peak0) peak0 = int'(cnt0);
    if (ov0 && !prev_ov0) rise0++;
    prev_ov0 = ov0;
    if (v0 && rdy0) acc0++;
    if (oh0 == 4'b1000) ones0++;
    if (cnt0 == 3'd4 && !rdy0) fullblk0++;
    if (ov1) seen1.push_back(oh1);
    if (ov1 && !prev_ov1) rise1++;
    prev_ov1 = ov1;
    step(0);
    step(1);
    @(posedge clk);
    chk_en = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0; msize[i] = 0; m_rem[i] = 0; m_on[i] = 1'b0; m_cur[i] = 2'b00;
    end
    peak0 = 0; rise0 = 0; acc0 = 0; ones0 = 0; fullblk0 = 0; rise1 = 0;
    prev_ov0 = 1'b0; prev_ov1 = 1'b0;
    rst0 = 1'b0; rst1 = 1'b0; v0 = 1'b0; v1 = 1'b0; c0 = 2'b00; c1 = 2'b00;

    // reset held two cycles
    tick(); tick();
    chk("rst_onehot", oh0, 0);
    chk("rst_valid", ov0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_ready", rdy0, 0);
    rst0 = 1'b1; rst1 = 1'b1;
    #1;
    chk("release_ready", rdy0, 1);

    // single code 10
    v0 = 1'b1; c0 = 2'b10;
    tick();
    v0 = 1'b0;
    chk("single_count", cnt0, 1);
    chk("single_not_yet", ov0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("single_word", oh0, 4'b0100);
      chk("single_valid", ov0, 1);
      chk("single_ready", rdy0, 1);
      tick();
    end
    chk("single_clear", oh0, 4'b0000);
    chk("single_clear_valid", ov0, 0);
    chk("single_ready_after", rdy0, 1);

    // burst of all four codes
    seen0.delete(); peak0 = 0; rise0 = 0;
    for (int k = 0; k < 4; k++) begin
      v0 = 1'b1; c0 = 2'(k);
      tick();
    end
    v0 = 1'b0;
    repeat (16) tick();
    chk("burst_len", seen0.size(), 12);
    for (int j = 0; j < 12 && j < seen0.size(); j++)
      chk("burst_word", seen0[j], 1 << (j / 3));
    chk("burst_peak", peak0, 3);
    chk("burst_nogap", rise0, 1);

    // overflow pressure with 11 repeated
    peak0 = 0; acc0 = 0; ones0 = 0; fullblk0 = 0;
    v0 = 1'b1; c0 = 2'b11;
    repeat (30) tick();
    v0 = 1'b0;
    repeat (25) tick();
    chk("ovf_peak", peak0, 4);
    chk("ovf_blocked", (fullblk0 > 0) ? 1 : 0, 1);
    chk("ovf_no_loss", ones0, 3 * acc0);
    chk("ovf_drained", cnt0, 0);

    // simultaneous push/pop at count 2
    seen0.delete();
    v0 = 1'b1; c0 = 2'b01; tick();
    c0 = 2'b10; tick();
    c0 = 2'b11; tick();
    v0 = 1'b0; tick();
    chk("pp_before", cnt0, 2);
    v0 = 1'b1; c0 = 2'b00; tick();
    v0 = 1'b0;
    chk("pp_after", cnt0, 2);
    chk("pp_popped", oh0, 4'b0100);
    repeat (14) tick();
    chk("pp_len", seen0.size(), 12);
    for (int j = 0; j < 12 && j < seen0.size(); j++)
      chk("pp_order", seen0[j], (j < 3) ? 4'b0010 : (j < 6) ? 4'b0100 : (j < 9) ? 4'b1000 : 4'b0001);

    // reset while 0010 is held with two entries queued
    v0 = 1'b1; c0 = 2'b01; tick();
    c0 = 2'b10; tick();
    c0 = 2'b11; tick();
    v0 = 1'b0;
    chk("mid_word", oh0, 4'b0010);
    chk("mid_queued", cnt0, 2);
    rst0 = 1'b0;
    tick();
    chk("mid_rst_onehot", oh0, 4'b0000);
    chk("mid_rst_valid", ov0, 0);
    chk("mid_rst_count", cnt0, 0);
    chk("mid_rst_ready", rdy0, 0);
    rst0 = 1'b1;
    rise0 = 0;
    repeat (10) tick();
    chk("mid_discarded", rise0, 0);

    // HOLD=1 instance: 01, 11, 00 back-to-back
    seen1.delete(); rise1 = 0;
    v1 = 1'b1; c1 = 2'b01; tick();
    c1 = 2'b11; tick();
    c1 = 2'b00; tick();
    v1 = 1'b0;
    repeat (6) tick();
    chk("h1_len", seen1.size(), 3);
    if (seen1.size() == 3) begin
      chk("h1_w0", seen1[0], 4'b0010);
      chk("h1_w1", seen1[1], 4'b1000);
      chk("h1_w2", seen1[2], 4'b0001);
    end
    chk("h1_nogap", rise1, 1);

    // randomized traffic on both instances, occasional reset
    for (int n = 0; n < 800; n++) begin
      rst0 = ($urandom_range(0, 59) != 0);
      rst1 = ($urandom_range(0, 59) != 0);
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 2) == 0);
      c0 = 2'($urandom_range(0, 3));
      c1 = 2'($urandom_range(0, 3));
      tick();
    end
    rst0 = 1'b1; rst1 = 1'b1; v0 = 1'b0; v1 = 1'b0;
    repeat (20) tick();
    chk("end_empty0", cnt0, 0);
    chk("end_idle0", ov0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
